bnn_frame_collector: RTL and testbench
======================================

Name: bnn_frame_collector

Overview:
Downstream stage of the BNN neuron. Captures the neuron's 1-bit decision outputs, one per valid strobe, and packs them into an N_BITS-wide frame. Keeps a running popcount and a majority vote for each frame. Presents the completed frame to the consumer (7-segment/readout logic or the next layer) over a valid/ready handshake.

Parameters:
N_BITS, 8, neuron decisions per frame (at least 2).
CNT_W, $clog2(N_BITS+1), width of the popcount field; derived, never overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous flush; discards the partial frame and any held frame.
bit_valid  input  1  bit_in is a new neuron decision this cycle.
bit_in  input  1  neuron output (o_neuron).
frame_ready  input  1  consumer accepts the frame.
frame_valid  output  1  a completed frame is held on the frame_* outputs.
frame_data  output  N_BITS  packed decisions; first bit received sits in bit 0.
frame_popcount  output  CNT_W  number of ones in frame_data.
frame_majority  output  1  1 when frame_popcount > N_BITS/2 (strictly greater; ties give 0).
overflow  output  1  sticky flag: a bit was dropped while a frame was held.

Behaviour:
- Async reset: state=COLLECT, idx=0, shift register=0, running count=0. frame_valid=0, frame_data=0, frame_popcount=0, frame_majority=0, overflow=0. Reset asserted mid-frame discards the frame with no other effect.
- FSM has two states, COLLECT and HOLD.
- COLLECT, bit_valid=1:
  - bit_in is written at position idx.
  - The running count increments when bit_in=1.
  - idx increments.
- COLLECT, accepted bit has idx==N_BITS-1:
  - Completed data, final count and majority are registered onto the frame_* outputs.
  - frame_valid rises at the same edge; state becomes HOLD.
  - idx, shift register and running count return to 0.
  - Latency: last bit accepted at edge k means frame_valid=1 during cycle k+1.
- COLLECT, bit_valid=0: no change.
- HOLD:
  - frame_* outputs stay stable until the handshake completes.
  - frame_valid & frame_ready at edge m: frame_valid=0 from cycle m+1, state returns to COLLECT. frame_data, frame_popcount and frame_majority keep their last values; they are don't-care while frame_valid=0.
  - bit_valid=1 in HOLD: the bit is dropped and overflow sets. This includes the handshake cycle itself, which is still HOLD. No skid buffer.
- frame_ready in COLLECT is ignored.
- clear=1 overrides everything at that edge:
  - state=COLLECT, idx=0, shift register/count=0.
  - frame_valid=0, overflow=0.
  - A bit_valid in the same cycle is discarded.
- Arithmetic:
  - The count is CNT_W wide and never wraps, since its maximum is N_BITS.
  - The majority threshold is the constant N_BITS/2 (integer division).
  - For odd N_BITS, (N_BITS+1)/2 ones gives majority=1.
- idx wraps only through the completion path; it never exceeds N_BITS-1.

Decomposition:
- Shared package bnn_pkg holds:
  - the state type (COLLECT, HOLD);
  - the default frame width constant BNN_FRAME_BITS=8;
  - the majority-threshold helper function.
- No sub-module. The running count is a single incrementer, so a separate popcount block adds nothing. The FSM, index counter and output register stay in one module (about 150 RTL lines).

Test Plan:
1. Reset, then bits 1,0,1,1,0,0,1,1 on consecutive cycles (frame_ready=0) -> frame_valid=1 the cycle after the 8th bit; frame_data=8'b11001101, popcount=5, majority=1, overflow=0.
2. Bits 1,1,1,1,0,0,0,0 -> popcount=4, majority=0 (tie rule); data=8'b00001111.
3. Hold the frame from test 1 with frame_ready=0 for 5 cycles and pulse bit_valid twice -> outputs unchanged, overflow=1 and sticky. Then frame_ready=1 -> frame_valid=0 next cycle. The next 8 bits form a fresh frame.
4. Gapped input: 8 bits of value 1 with bit_valid toggling every other cycle -> frame_valid after the 8th accepted bit only; data=8'hFF, popcount=8, majority=1.
5. After 5 bits, assert clear (with bit_valid=1 in the same cycle), then send 8 bits of 0 -> frame_data=8'h00, popcount=0. No residue from the flushed bits; overflow=0.
6. rst_n low asynchronously mid-frame (between clock edges) and while HOLD -> all outputs 0 immediately. After release, the next 8 bits complete a frame normally.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN output stage: FSM state type,
// default frame width and the majority-threshold helper.
package bnn_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int BNN_FRAME_BITS = 8;

  // Majority needs strictly more ones than this (integer half, ties lose).
  function automatic int majority_threshold(input int n_bits);
    return n_bits / 2;
  endfunction

endpackage

// File: rtl/bnn_frame_collector.sv
// Packs 1-bit neuron decisions into an N_BITS frame with popcount/majority.
// Frame valid the cycle after the last bit; bits arriving while a frame is held are dropped (sticky overflow).
module bnn_frame_collector
  import bnn_pkg::*;
#(
  parameter int  N_BITS = BNN_FRAME_BITS,
  localparam int CNT_W  = $clog2(N_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [N_BITS-1:0] frame_data,
  output logic [CNT_W-1:0]  frame_popcount,
  output logic              frame_majority,
  output logic              overflow
);

  localparam int IDX_W  = $clog2(N_BITS);
  localparam int THRESH = majority_threshold(N_BITS);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [N_BITS-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  logic [N_BITS-1:0] next_data;
  logic [CNT_W-1:0]  next_cnt;
  logic              idx_last;

  // Frame contents as they would look with the current bit merged in, so the
  // completing bit can be registered straight onto the outputs.
  always_comb begin
    next_data      = shreg;
    next_data[idx] = bit_in;
    next_cnt       = cnt + CNT_W'(bit_in);
    idx_last       = (idx == IDX_W'(N_BITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= COLLECT;
      idx            <= '0;
      shreg          <= '0;
      cnt            <= '0;
      frame_valid    <= 1'b0;
      frame_data     <= '0;
      frame_popcount <= '0;
      frame_majority <= 1'b0;
      overflow       <= 1'b0;
    end else if (clear) begin
      state       <= COLLECT;
      idx         <= '0;
      shreg       <= '0;
      cnt         <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (bit_valid) begin
            if (idx_last) begin
              frame_data     <= next_data;
              frame_popcount <= next_cnt;
              frame_majority <= (next_cnt > CNT_W'(THRESH));
              frame_valid    <= 1'b1;
              state          <= HOLD;
              idx            <= '0;
              shreg          <= '0;
              cnt            <= '0;
            end else begin
              shreg <= next_data;
              cnt   <= next_cnt;
              idx   <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          // No skid buffer: anything arriving here, handshake cycle included, is lost.
          if (bit_valid) overflow <= 1'b1;
          if (frame_ready) begin
            frame_valid <= 1'b0;
            state       <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_frame_collector.sv
// Directed bench for bnn_frame_collector: inputs driven and outputs sampled on the falling edge.
module tb_bnn_frame_collector;

  localparam int N = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          bit_valid;
  logic          bit_in;
  logic          frame_ready;
  logic          frame_valid;
  logic [N-1:0]  frame_data;
  logic [CW-1:0] frame_popcount;
  logic          frame_majority;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  bnn_frame_collector #(.N_BITS(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .bit_valid      (bit_valid),
    .bit_in         (bit_in),
    .frame_ready    (frame_ready),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .frame_popcount (frame_popcount),
    .frame_majority (frame_majority),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [N-1:0] d, input logic [CW-1:0] pc,
                           input logic maj, input logic ovf);
    chk({tag, ".valid"}, 32'(frame_valid), 32'd1);
    chk({tag, ".data"}, 32'(frame_data), 32'(d));
    chk({tag, ".popcount"}, 32'(frame_popcount), 32'(pc));
    chk({tag, ".majority"}, 32'(frame_majority), 32'(maj));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(frame_valid), 32'd0);
    chk({tag, ".data"}, 32'(frame_data), 32'd0);
    chk({tag, ".popcount"}, 32'(frame_popcount), 32'd0);
    chk({tag, ".majority"}, 32'(frame_majority), 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
  endtask

  // Set inputs at the next falling edge; they are taken on the rising edge after.
  task automatic drive(input logic v, input logic b);
    @(negedge clk);
    bit_valid = v;
    bit_in    = b;
  endtask

  // Send a frame LSB-first, then idle one cycle so the completed frame is visible.
  task automatic send_frame(input logic [N-1:0] bits);
    for (int i = 0; i < N; i++) drive(1'b1, bits[i]);
    drive(1'b0, 1'b0);
  endtask

  task automatic handshake(input string tag, input logic v);
    @(negedge clk);
    frame_ready = 1'b1;
    bit_valid   = v;
    bit_in      = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    chk({tag, ".valid_drop"}, 32'(frame_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Test 1: 1,0,1,1,0,0,1,1 -> 8'b11001101
    for (int i = 0; i < N - 1; i++) drive(1'b1, (8'b11001101 >> i) & 1'b1);
    @(negedge clk);
    chk("t1.valid_before_last", 32'(frame_valid), 32'd0);
    bit_valid = 1'b1; bit_in = 1'b1;
    drive(1'b0, 1'b0);
    chk_frame("t1", 8'b11001101, 4'd5, 1'b1, 1'b0);

    // Test 3: hold with dropped bits, then release
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk_frame("t3.hold", 8'b11001101, 4'd5, 1'b1, 1'b1);
    handshake("t3", 1'b0);
    chk("t3.overflow_sticky", 32'(overflow), 32'd1);

    // Test 2: tie gives no majority
    send_frame(8'b00001111);
    chk_frame("t2", 8'b00001111, 4'd4, 1'b0, 1'b1);
    handshake("t2", 1'b0);

    // Test 4: gapped input of all ones
    for (int i = 0; i < N - 1; i++) begin
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b0);
    end
    chk("t4.valid_before_last", 32'(frame_valid), 32'd0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    chk_frame("t4", 8'hFF, 4'd8, 1'b1, 1'b1);
    handshake("t4", 1'b0);

    // Test 5: clear after 5 bits with a colliding bit_valid
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    @(negedge clk);
    clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    clear = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    chk("t5.clear_overflow", 32'(overflow), 32'd0);
    chk("t5.clear_valid", 32'(frame_valid), 32'd0);
    send_frame(8'h00);
    chk_frame("t5", 8'h00, 4'd0, 1'b0, 1'b0);

    // Bit arriving on the handshake cycle is dropped and flags overflow
    handshake("t5b", 1'b1);
    chk("t5b.overflow", 32'(overflow), 32'd1);
    send_frame(8'b00000010);
    chk_frame("t5b", 8'b00000010, 4'd1, 1'b0, 1'b1);

    // Test 6: async reset mid-frame (outputs still hold the previous frame)
    handshake("t6pre", 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t6.reset_midframe");
    #4 rst_n = 1'b1;
    send_frame(8'b10000001);
    chk_frame("t6.after_mid", 8'b10000001, 4'd2, 1'b0, 1'b0);

    // Async reset while holding a frame
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_zero("t6.reset_hold");
    #4 rst_n = 1'b1;
    send_frame(8'b01110110);
    chk_frame("t6.after_hold", 8'b01110110, 4'd5, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
